// File: rtl/iob_axis_s_axi_m_write_sched.sv
// Write-descriptor scheduler: arbitrates requesters, splits descriptors into engine-sized chunks.
// Define IOB_AXIS_S_AXI_M_WRITE_SCHED_RR_EN for round-robin arbitration (fixed priority otherwise).
module iob_axis_s_axi_m_write_sched #(
    parameter int N_REQ       = 2,
    parameter int AXI_ADDR_W  = 32,
    parameter int AXI_LEN_W   = 8,
    parameter int TOTAL_LEN_W = 16
) (
    input  logic                            clk_i,
    input  logic                            arst_n_i,
    input  logic                            cke_i,
    input  logic [N_REQ-1:0]                req_valid_i,
    input  logic [N_REQ*AXI_ADDR_W-1:0]     req_addr_i,
    input  logic [N_REQ*TOTAL_LEN_W-1:0]    req_len_i,
    output logic [N_REQ-1:0]                req_ready_o,
    output logic [N_REQ-1:0]                req_done_o,
    output logic [N_REQ-1:0]                grant_o,
    output logic                            w_start_transfer_o,
    output logic [AXI_ADDR_W-1:0]           w_addr_o,
    output logic [AXI_LEN_W:0]              w_length_o,
    input  logic                            w_busy_i,
    output logic                            busy_o
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW    = (TOTAL_LEN_W > AXI_LEN_W + 1) ? TOTAL_LEN_W : AXI_LEN_W + 1;
    localparam logic [CW-1:0] MAX_CHUNK = CW'(2 ** AXI_LEN_W);

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, WAIT} state_t;

    state_t                   state_q, state_d;
    logic [N_REQ-1:0]         ready_q, ready_d, done_q, done_d, grant_q, grant_d;
    logic                     start_q, start_d;
    logic [AXI_ADDR_W-1:0]    waddr_q, waddr_d, addr_q, addr_d;
    logic [AXI_LEN_W:0]       wlen_q, wlen_d;
    logic [TOTAL_LEN_W-1:0]   rem_q, rem_d;

    logic                     sel_found;
    logic [IDX_W-1:0]         sel_idx;
    logic [N_REQ-1:0]         sel_oh;
    logic [AXI_ADDR_W-1:0]    sel_addr;
    logic [TOTAL_LEN_W-1:0]   sel_len;
    logic [CW-1:0]            rem_w, chunk_w;
    logic [AXI_LEN_W:0]       chunk_len;

`ifdef IOB_AXIS_S_AXI_M_WRITE_SCHED_RR_EN
    logic [IDX_W-1:0]         last_q, last_d;

    // Search begins just after the last winner so every requester gets a turn.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!sel_found && req_valid_i[(int'(last_q) + i) % N_REQ]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'((int'(last_q) + i) % N_REQ);
            end
        end
    end
`else
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!sel_found && req_valid_i[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        sel_oh          = '0;
        sel_oh[sel_idx] = 1'b1;
    end

    assign sel_addr  = req_addr_i[int'(sel_idx)*AXI_ADDR_W +: AXI_ADDR_W];
    assign sel_len   = req_len_i[int'(sel_idx)*TOTAL_LEN_W +: TOTAL_LEN_W];
    assign rem_w     = CW'(rem_q);
    assign chunk_w   = (rem_w > MAX_CHUNK) ? MAX_CHUNK : rem_w;
    assign chunk_len = chunk_w[AXI_LEN_W:0];

    always_comb begin
        state_d = state_q;
        ready_d = '0;
        done_d  = '0;
        grant_d = grant_q;
        start_d = 1'b0;
        waddr_d = waddr_q;
        wlen_d  = wlen_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
`ifdef IOB_AXIS_S_AXI_M_WRITE_SCHED_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    ready_d = sel_oh;
                    addr_d  = sel_addr;
                    rem_d   = sel_len;
`ifdef IOB_AXIS_S_AXI_M_WRITE_SCHED_RR_EN
                    last_d  = sel_idx;
`endif
                    // Empty descriptors complete on accept without touching the engine.
                    if (sel_len == '0) begin
                        done_d = sel_oh;
                    end else begin
                        grant_d = sel_oh;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                start_d = 1'b1;
                waddr_d = addr_q;
                wlen_d  = chunk_len;
                addr_d  = addr_q + (AXI_ADDR_W'(chunk_len) << 2);
                rem_d   = rem_q - TOTAL_LEN_W'(chunk_len);
                state_d = SETTLE;
            end
            // Engine busy lags start by a cycle, so it is not trusted here.
            SETTLE: state_d = WAIT;
            WAIT: begin
                if (!w_busy_i) begin
                    if (rem_q != '0) begin
                        state_d = ISSUE;
                    end else begin
                        done_d  = grant_q;
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            ready_q <= '0;
            done_q  <= '0;
            grant_q <= '0;
            start_q <= 1'b0;
            waddr_q <= '0;
            wlen_q  <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
`ifdef IOB_AXIS_S_AXI_M_WRITE_SCHED_RR_EN
            last_q  <= IDX_W'(N_REQ - 1);
`endif
        end else if (cke_i) begin
            state_q <= state_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            grant_q <= grant_d;
            start_q <= start_d;
            waddr_q <= waddr_d;
            wlen_q  <= wlen_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
`ifdef IOB_AXIS_S_AXI_M_WRITE_SCHED_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign req_ready_o        = ready_q;
    assign req_done_o         = done_q;
    assign grant_o            = grant_q;
    assign w_start_transfer_o = start_q;
    assign w_addr_o           = waddr_q;
    assign w_length_o         = wlen_q;
    assign busy_o             = (state_q != IDLE);

endmodule
